// File: rtl/cpu_ctrl_pkg.sv
// Shared encodings for the multicycle control unit: FSM states, ALU codes, opcode and cmd values.
// Pure declarations, no logic; imported by the decoder sub-module and the control top.
// The state values are visible on the debug state_o port, so keep them stable.
package cpu_ctrl_pkg;

    typedef enum logic [3:0] {
        ST_FETCH  = 4'd0,
        ST_DECODE = 4'd1,
        ST_MEMADR = 4'd2,
        ST_MEMRD  = 4'd3,
        ST_MEMWB  = 4'd4,
        ST_MEMWR  = 4'd5,
        ST_EXECR  = 4'd6,
        ST_EXECI  = 4'd7,
        ST_ALUWB  = 4'd8,
        ST_BRANCH = 4'd9
    } state_t;

    // ALUControl codes
    localparam logic [1:0] ALU_ADD = 2'b00;
    localparam logic [1:0] ALU_SUB = 2'b01;
    localparam logic [1:0] ALU_AND = 2'b10;
    localparam logic [1:0] ALU_ORR = 2'b11;

    // Op field (instr[27:26])
    localparam logic [1:0] OP_DP  = 2'b00;
    localparam logic [1:0] OP_MEM = 2'b01;
    localparam logic [1:0] OP_BR  = 2'b10;
    localparam logic [1:0] OP_UND = 2'b11;

    // Data-processing cmd field (Funct[4:1])
    localparam logic [3:0] CMD_AND = 4'b0000;
    localparam logic [3:0] CMD_SUB = 4'b0010;
    localparam logic [3:0] CMD_ADD = 4'b0100;
    localparam logic [3:0] CMD_CMP = 4'b1010;
    localparam logic [3:0] CMD_ORR = 4'b1100;

    // Flag-write request patterns: all four flags, or only N/Z
    localparam logic [1:0] FLAGW_NONE = 2'b00;
    localparam logic [1:0] FLAGW_NZ   = 2'b10;
    localparam logic [1:0] FLAGW_ALL  = 2'b11;

endpackage

// File: rtl/alu_decoder.sv
// Maps a data-processing cmd and S bit to ALU operation, flag-write request and write suppression.
// Purely combinational, zero cycles.
// No handshake; outputs follow inputs.
module alu_decoder
    import cpu_ctrl_pkg::*;
(
    input  logic       alu_op,
    input  logic [3:0] cmd,
    input  logic       s_bit,
    output logic [1:0] alu_control,
    output logic [1:0] flag_w,
    output logic       no_write
);

    // Decode cmd when the FSM is in an execute state; otherwise plain ADD with no side effects
    always_comb begin
        alu_control = ALU_ADD;
        flag_w      = FLAGW_NONE;
        no_write    = 1'b0;
        if (alu_op) begin
            case (cmd)
                CMD_ADD: begin
                    alu_control = ALU_ADD;
                    flag_w      = s_bit ? FLAGW_ALL : FLAGW_NONE;
                end
                CMD_SUB: begin
                    alu_control = ALU_SUB;
                    flag_w      = s_bit ? FLAGW_ALL : FLAGW_NONE;
                end
                CMD_AND: begin
                    alu_control = ALU_AND;
                    flag_w      = s_bit ? FLAGW_NZ : FLAGW_NONE;
                end
                CMD_ORR: begin
                    alu_control = ALU_ORR;
                    flag_w      = s_bit ? FLAGW_NZ : FLAGW_NONE;
                end
                // CMP always updates all flags and never writes the destination register
                CMD_CMP: begin
                    alu_control = ALU_SUB;
                    flag_w      = FLAGW_ALL;
                    no_write    = 1'b1;
                end
                // Unsupported cmd: harmless ADD with the register write suppressed
                default: begin
                    alu_control = ALU_ADD;
                    flag_w      = FLAGW_NONE;
                    no_write    = 1'b1;
                end
            endcase
        end
    end

endmodule

// File: rtl/multicycle_decoder.sv
// Multicycle control unit: Moore FSM plus ALU decode driving datapath selects and raw write strobes.
// One state per cycle; LDR 5, STR 4, DP 4, B 3, undefined 2 cycles from FETCH back to FETCH.
// No backpressure; the FSM advances every clock, and reset abandons the current instruction.
module multicycle_decoder
    import cpu_ctrl_pkg::*;
#(
    parameter logic [3:0] PC_REG = 4'd15
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [1:0] Op,
    input  logic [5:0] Funct,
    input  logic [3:0] Rd,
    output logic       IRWrite,
    output logic       NextPC,
    output logic       AdrSrc,
    output logic       ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic [1:0] ResultSrc,
    output logic [1:0] ImmSrc,
    output logic [1:0] RegSrc,
    output logic [1:0] ALUControl,
    output logic [1:0] FlagW,
    output logic       NoWrite,
    output logic       PCS,
    output logic       RegW,
    output logic       MemW,
    output logic [3:0] state_o
);

    state_t     state;
    state_t     next_state;

    // Raw Moore outputs before reset gating
    logic       ir_write;
    logic       next_pc;
    logic       adr_src;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] result_src;
    logic       reg_w;
    logic       mem_w;
    logic       branch;
    logic       alu_op;

    // cmd and S captured in DECODE so execute/writeback do not depend on Funct staying stable
    logic [4:0] funct_q;
    logic       no_write_q;

    logic [1:0] dec_alu_control;
    logic [1:0] dec_flag_w;
    logic       dec_no_write;

    logic       in_exec;
    logic       in_aluwb;

    assign in_exec  = (state == ST_EXECR) || (state == ST_EXECI);
    assign in_aluwb = (state == ST_ALUWB);

    // State register; reset returns to FETCH immediately
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= ST_FETCH;
        end else begin
            state <= next_state;
        end
    end

    // Next-state selection from the current state and the decoded instruction fields
    always_comb begin
        next_state = ST_FETCH;
        case (state)
            ST_FETCH:  next_state = ST_DECODE;
            ST_DECODE: begin
                case (Op)
                    OP_MEM:  next_state = ST_MEMADR;
                    OP_DP:   next_state = Funct[5] ? ST_EXECI : ST_EXECR;
                    OP_BR:   next_state = ST_BRANCH;
                    default: next_state = ST_FETCH;
                endcase
            end
            ST_MEMADR: next_state = Funct[0] ? ST_MEMRD : ST_MEMWR;
            ST_MEMRD:  next_state = ST_MEMWB;
            ST_EXECR:  next_state = ST_ALUWB;
            ST_EXECI:  next_state = ST_ALUWB;
            default:   next_state = ST_FETCH;
        endcase
    end

    // Per-state Moore outputs; anything not set here stays zero
    always_comb begin
        ir_write   = 1'b0;
        next_pc    = 1'b0;
        adr_src    = 1'b0;
        alu_src_a  = 1'b0;
        alu_src_b  = 2'b00;
        result_src = 2'b00;
        reg_w      = 1'b0;
        mem_w      = 1'b0;
        branch     = 1'b0;
        alu_op     = 1'b0;
        case (state)
            ST_FETCH: begin
                ir_write   = 1'b1;
                next_pc    = 1'b1;
                alu_src_a  = 1'b1;
                alu_src_b  = 2'b10;
                result_src = 2'b10;
            end
            ST_DECODE: begin
                alu_src_a  = 1'b1;
                alu_src_b  = 2'b10;
                result_src = 2'b10;
            end
            ST_MEMADR: alu_src_b = 2'b01;
            ST_MEMRD:  adr_src   = 1'b1;
            ST_MEMWB: begin
                result_src = 2'b01;
                reg_w      = 1'b1;
            end
            ST_MEMWR: begin
                adr_src = 1'b1;
                mem_w   = 1'b1;
            end
            ST_EXECR:  alu_op = 1'b1;
            ST_EXECI: begin
                alu_src_b = 2'b01;
                alu_op    = 1'b1;
            end
            ST_ALUWB:  reg_w = 1'b1;
            ST_BRANCH: begin
                alu_src_b  = 2'b01;
                result_src = 2'b10;
                branch     = 1'b1;
            end
            default: ;
        endcase
    end

    // Capture cmd/S on leaving DECODE and hold the write-suppress decision into ALUWB
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            funct_q    <= 5'd0;
            no_write_q <= 1'b0;
        end else begin
            if (state == ST_DECODE) begin
                funct_q <= Funct[4:0];
            end
            if (in_exec) begin
                no_write_q <= dec_no_write;
            end
        end
    end

    alu_decoder u_alu_decoder (
        .alu_op      (alu_op),
        .cmd         (funct_q[4:1]),
        .s_bit       (funct_q[0]),
        .alu_control (dec_alu_control),
        .flag_w      (dec_flag_w),
        .no_write    (dec_no_write)
    );

    // Selects pass straight through; during reset the state is already FETCH so they show FETCH values
    assign AdrSrc     = adr_src;
    assign ALUSrcA    = alu_src_a;
    assign ALUSrcB    = alu_src_b;
    assign ResultSrc  = result_src;
    assign ALUControl = dec_alu_control;
    assign ImmSrc     = Op;
    assign RegSrc     = {(Op == OP_MEM), (Op == OP_BR)};
    assign state_o    = state;

    // Write strobes are forced low for as long as reset is held, not just until the next edge
    assign IRWrite = ir_write & ~reset;
    assign NextPC  = next_pc  & ~reset;
    assign RegW    = reg_w    & ~reset;
    assign MemW    = mem_w    & ~reset;
    assign FlagW   = reset ? FLAGW_NONE : dec_flag_w;
    assign NoWrite = ~reset & ((in_exec & dec_no_write) | (in_aluwb & no_write_q));
    assign PCS     = ~reset & (branch | (reg_w & (Rd == PC_REG)));

endmodule
